// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        STABLE = 2'd1,
        RUN    = 2'd2
    } pll_seq_state_t;

    localparam logic [7:0] LOST_CNT_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single-bit asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies PLL lock, releases system reset after stable lock, generates a fractional clock enable.
// Define PLL_SEQ_LOST_CNT_EN to build the saturating lock-loss counter; otherwise lost_count is 0.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned           STABLE_CYCLES = 1024,
    parameter int unsigned           ACC_W         = 24,
    parameter logic [ACC_W-1:0]      PHASE_INC     = 24'd1251142
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       sys_reset_n,
    output logic       clk_en,
    output logic       lock_lost,
    output logic [7:0] lost_count
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic           lk;
    pll_seq_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (pll_locked),
        .q      (lk)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            acc_q       <= '0;
            clk_en      <= 1'b0;
            sys_reset_n <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            // Accumulator and strobe only advance while staying in RUN.
            lock_lost <= 1'b0;
            clk_en    <= 1'b0;
            acc_q     <= '0;
            case (state_q)
                HOLD: begin
                    sys_reset_n <= 1'b0;
                    cnt_q       <= '0;
                    if (lk) state_q <= STABLE;
                end
                STABLE: begin
                    if (!lk) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= RUN;
                        sys_reset_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_q     <= HOLD;
                        sys_reset_n <= 1'b0;
                        lock_lost   <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        {clk_en, acc_q} <= {1'b0, acc_q} + {1'b0, PHASE_INC};
                    end
                end
                default: begin
                    state_q     <= HOLD;
                    sys_reset_n <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_LOST_CNT_EN
    logic [7:0] lost_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lost_cnt_q <= 8'd0;
        end else if (state_q == RUN && !lk && lost_cnt_q != LOST_CNT_MAX) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lost_count = lost_cnt_q;
`else
    assign lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer (two parameterisations).
module tb_pll_lock_sequencer;

`ifdef PLL_SEQ_LOST_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n, pll_locked;
    logic       sys_reset_n_a, clk_en_a, lock_lost_a;
    logic [7:0] lost_count_a;
    logic       reset_n_b, pll_locked_b;
    logic       sys_reset_n_b, clk_en_b, lock_lost_b;
    logic [7:0] lost_count_b;

    int n_checks = 0;
    int n_errors = 0;
    int ll_cnt   = 0;
    int ce_cnt   = 0;

    pll_lock_sequencer #(
        .STABLE_CYCLES(16),
        .ACC_W        (24),
        .PHASE_INC    (24'h400000)
    ) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .sys_reset_n(sys_reset_n_a),
        .clk_en     (clk_en_a),
        .lock_lost  (lock_lost_a),
        .lost_count (lost_count_a)
    );

    pll_lock_sequencer #(
        .STABLE_CYCLES(2),
        .ACC_W        (8),
        .PHASE_INC    (8'd37)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n_b),
        .pll_locked (pll_locked_b),
        .sys_reset_n(sys_reset_n_b),
        .clk_en     (clk_en_b),
        .lock_lost  (lock_lost_b),
        .lost_count (lost_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (lock_lost_a) ll_cnt++;
        if (clk_en_a) ce_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] exp_lost(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    initial begin
        int ll0, ce0, timeouts, ones, pairs, first_idx;
        logic prev;
        reset_n = 1'b1; pll_locked = 1'b0;
        reset_n_b = 1'b1; pll_locked_b = 1'b0;
        #2;
        reset_n = 1'b0; reset_n_b = 1'b0;
        #1;
        check_eq("rst_sys", sys_reset_n_a, 0);
        check_eq("rst_clk_en", clk_en_a, 0);
        check_eq("rst_lock_lost", lock_lost_a, 0);
        check_eq("rst_lost_count", lost_count_a, 0);
        step(2);
        reset_n = 1'b1;
        step(2);

        // Clean lock: pll_locked rises just after edge 0.
        pll_locked = 1'b1;
        step(18);
        check_eq("rel_e18", sys_reset_n_a, 0);
        step(1);
        check_eq("rel_e19", sys_reset_n_a, 1);
        check_eq("ce_e19", clk_en_a, 0);
        step(3);
        check_eq("ce_e22", clk_en_a, 0);
        step(1);
        check_eq("ce_e23", clk_en_a, 1);
        step(1);
        check_eq("ce_e24", clk_en_a, 0);
        step(3);
        check_eq("ce_e27", clk_en_a, 1);

        // Loss of lock in RUN.
        ll0 = ll_cnt;
        pll_locked = 1'b0;
        step(2);
        check_eq("loss_e2_sys", sys_reset_n_a, 1);
        check_eq("loss_e2_ll", lock_lost_a, 0);
        step(1);
        check_eq("loss_e3_sys", sys_reset_n_a, 0);
        check_eq("loss_e3_ll", lock_lost_a, 1);
        check_eq("loss_e3_ce", clk_en_a, 0);
        check_eq("loss_cnt1", lost_count_a, exp_lost(1));
        step(1);
        check_eq("loss_e4_ll", lock_lost_a, 0);
        ce0 = ce_cnt;
        step(20);
        check_eq("loss_ce_quiet", ce_cnt - ce0, 0);
        check_eq("loss_ll_width", ll_cnt - ll0, 1);

        // One-cycle dropout during STABLE restarts qualification.
        ll0 = ll_cnt;
        pll_locked = 1'b1;
        step(10);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(8);
        check_eq("glitch_e19", sys_reset_n_a, 0);
        step(10);
        check_eq("glitch_e29", sys_reset_n_a, 0);
        step(1);
        check_eq("glitch_e30", sys_reset_n_a, 1);
        check_eq("glitch_no_ll", ll_cnt - ll0, 0);
        check_eq("glitch_cnt", lost_count_a, exp_lost(1));

        // Async reset mid-RUN with accumulator at 0x800000.
        step(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_sys", sys_reset_n_a, 0);
        check_eq("arst_ce", clk_en_a, 0);
        check_eq("arst_ll", lock_lost_a, 0);
        check_eq("arst_cnt", lost_count_a, 0);
        step(3);
        reset_n = 1'b1;
        step(18);
        check_eq("arst_rel_e18", sys_reset_n_a, 0);
        step(1);
        check_eq("arst_rel_e19", sys_reset_n_a, 1);
        step(3);
        check_eq("arst_ce_e22", clk_en_a, 0);
        step(1);
        check_eq("arst_ce_e23", clk_en_a, 1);

        // Saturation over 300 lock/lose cycles, starting from a clean reset.
        pll_locked = 1'b0;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        ll0 = ll_cnt;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            int w;
            pll_locked = 1'b1;
            w = 0;
            while (sys_reset_n_a !== 1'b1 && w < 40) begin
                step(1);
                w++;
            end
            if (w >= 40) timeouts++;
            pll_locked = 1'b0;
            step(4);
            if (i == 99) check_eq("sat_mid", lost_count_a, exp_lost(100));
        end
        check_eq("sat_timeout", timeouts, 0);
        check_eq("sat_ll_pulses", ll_cnt - ll0, 300);
        check_eq("sat_final", lost_count_a, exp_lost(300));

        // Strobe density with small accumulator: 37 strobes per 256 RUN cycles.
        step(1);
        reset_n_b = 1'b1;
        step(1);
        pll_locked_b = 1'b1;
        step(4);
        check_eq("b_rel_e4", sys_reset_n_b, 0);
        step(1);
        check_eq("b_rel_e5", sys_reset_n_b, 1);
        ones = 0; pairs = 0; first_idx = -1; prev = 1'b0;
        for (int k = 6; k <= 261; k++) begin
            step(1);
            if (clk_en_b) begin
                ones++;
                if (first_idx < 0) first_idx = k;
                if (prev) pairs++;
            end
            prev = clk_en_b;
        end
        check_eq("b_strobes", ones, 37);
        check_eq("b_width", pairs, 0);
        check_eq("b_first", first_idx, 12);
        check_eq("b_ll", lock_lost_b, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
